// File: rtl/alu_pkg.sv
// Shared types for the ALU command front-end: opcodes, sequencer states
// and the command word buffered between the source and the ALU.
package alu_pkg;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_XOR = 3'd3;
    localparam logic [2:0] OP_MUL = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP
    } seq_state_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
    } alu_cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with head-of-queue read data; pointers carry one extra
// wrap bit so that full and empty are distinguishable.
module cmd_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the tiny ALU: queues commands, issues them one at a
// time with a held start, qualifies done by minimum latency, returns results.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT     = 15,
    parameter int MIN_LAT_ALU = 1,
    parameter int MIN_LAT_MUL = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic [2:0]  cmd_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_op,
    output logic        alu_start,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [2:0]  rsp_op,
    output logic        rsp_err,
    output logic        busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int CMD_W = $bits(alu_cmd_t);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] MIN_ALU_CNT = CNT_W'(MIN_LAT_ALU);
    localparam logic [CNT_W-1:0] MIN_MUL_CNT = CNT_W'(MIN_LAT_MUL);

    alu_cmd_t          push_cmd;
    alu_cmd_t          head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    seq_state_t        state, state_nxt;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
    logic [CNT_W-1:0]  min_lat;
    logic              done_ok;
    logic [7:0]        alu_a_nxt, alu_b_nxt;
    logic [2:0]        alu_op_nxt, rsp_op_nxt;
    logic              alu_start_nxt, rsp_valid_nxt, rsp_err_nxt;
    logic [15:0]       rsp_result_nxt;

    assign push_cmd  = '{a: cmd_a, b: cmd_b, op: cmd_op};
    assign cmd_ready = !fifo_full;
    assign busy      = !fifo_empty || (state != S_IDLE);

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (cmd_valid && cmd_ready),
        .wdata   (push_cmd),
        .pop     (pop),
        .rdata   (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // A done seen before the minimum latency is a leftover from the previous op.
    assign min_lat = (alu_op == OP_MUL) ? MIN_MUL_CNT : MIN_ALU_CNT;
    assign done_ok = alu_done && (wait_cnt >= min_lat);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            alu_start  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_op     <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_cnt_nxt;
            alu_a      <= alu_a_nxt;
            alu_b      <= alu_b_nxt;
            alu_op     <= alu_op_nxt;
            alu_start  <= alu_start_nxt;
            rsp_valid  <= rsp_valid_nxt;
            rsp_result <= rsp_result_nxt;
            rsp_op     <= rsp_op_nxt;
            rsp_err    <= rsp_err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        wait_cnt_nxt   = wait_cnt;
        alu_a_nxt      = alu_a;
        alu_b_nxt      = alu_b;
        alu_op_nxt     = alu_op;
        alu_start_nxt  = alu_start;
        rsp_valid_nxt  = rsp_valid;
        rsp_result_nxt = rsp_result;
        rsp_op_nxt     = rsp_op;
        rsp_err_nxt    = rsp_err;
        pop            = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    rsp_op_nxt = head.op;
                    case (head.op)
                        OP_ADD, OP_AND, OP_XOR, OP_MUL: begin
                            alu_a_nxt     = head.a;
                            alu_b_nxt     = head.b;
                            alu_op_nxt    = head.op;
                            alu_start_nxt = 1'b1;
                            wait_cnt_nxt  = '0;
                            state_nxt     = S_ISSUE;
                        end
                        OP_NOP: begin
                            rsp_result_nxt = '0;
                            rsp_err_nxt    = 1'b0;
                            state_nxt      = S_RESP;
                        end
                        default: begin
                            rsp_result_nxt = '0;
                            rsp_err_nxt    = 1'b1;
                            state_nxt      = S_RESP;
                        end
                    endcase
                end
            end
            S_ISSUE: begin
                wait_cnt_nxt = wait_cnt + CNT_W'(1);
                if (done_ok) begin
                    rsp_result_nxt = (alu_op == OP_MUL) ? alu_result : {8'h00, alu_result[7:0]};
                    rsp_err_nxt    = 1'b0;
                    alu_start_nxt  = 1'b0;
                    rsp_valid_nxt  = 1'b1;
                    state_nxt      = S_RESP;
                end else if (wait_cnt == TIMEOUT_CNT) begin
                    rsp_result_nxt = '0;
                    rsp_err_nxt    = 1'b1;
                    alu_start_nxt  = 1'b0;
                    rsp_valid_nxt  = 1'b1;
                    state_nxt      = S_RESP;
                end
            end
            S_RESP: begin
                // Locally handled ops enter here with valid still low and present one cycle later.
                if (!rsp_valid) begin
                    rsp_valid_nxt = 1'b1;
                end else if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomised bench for alu_cmd_sequencer with an ALU stand-in, an in-order
// response scoreboard and a few directed scenarios pinned to literal values.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    localparam int FIFO_DEPTH  = 4;
    localparam int TIMEOUT     = 15;
    localparam int MIN_LAT_ALU = 1;
    localparam int MIN_LAT_MUL = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_a = '0;
    logic [7:0]  cmd_b = '0;
    logic [2:0]  cmd_op = '0;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_op;
    logic        alu_start;
    logic        alu_done = 1'b0;
    logic [15:0] alu_result = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_result;
    logic [2:0]  rsp_op;
    logic        rsp_err;
    logic        busy;

    alu_cmd_sequencer #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .TIMEOUT     (TIMEOUT),
        .MIN_LAT_ALU (MIN_LAT_ALU),
        .MIN_LAT_MUL (MIN_LAT_MUL)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_op     (cmd_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_start  (alu_start),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_op     (rsp_op),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    initial forever #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int n_hs = 0;
    int n_starts = 0;
    alu_cmd_t q[$];

    // ready_mode: 0 always ready, 1 never ready, 2 random
    // dmode: 0 random delay, 1 done stuck high, 2 done never, 3 fixed delay dfix
    int ready_mode = 0;
    int dmode = 3;
    int dfix = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [15:0] model(alu_cmd_t c);
        logic [7:0] lo;
        case (c.op)
            3'd1:    lo = c.a + c.b;
            3'd2:    lo = c.a & c.b;
            3'd3:    lo = c.a ^ c.b;
            default: lo = 8'h00;
        endcase
        if (c.op == 3'd4) return 16'(c.a) * 16'(c.b);
        return {8'h00, lo};
    endfunction

    function automatic bit is_alu(logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd4);
    endfunction

    // Accepted commands and response handshakes, sampled just before the edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset_n) begin
            if (cmd_valid && cmd_ready) q.push_back('{a: cmd_a, b: cmd_b, op: cmd_op});
            if (rsp_valid && rsp_ready && q.size() != 0) begin
                void'(q.pop_front());
                n_hs <= n_hs + 1;
            end
        end
    end

    // ALU stand-in plus per-cycle scoreboard, run away from the active edge.
    logic     prev_start = 1'b0;
    logic     prev_rv = 1'b0;
    int       since = 0;
    int       dly = 0;
    int       issue_cyc = 0;
    int       exp_lat = 0;
    bit       cur_to = 1'b0;
    alu_cmd_t c;
    logic [15:0] ev;
    logic        ee;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_start = 1'b0;
            prev_rv    = 1'b0;
            cur_to     = 1'b0;
            alu_done   = 1'b0;
        end else begin
            if (alu_start && !prev_start) begin
                int eff;
                int ml;
                n_starts++;
                since = 0;
                case (dmode)
                    0:       dly = $urandom_range(0, 18);
                    1:       dly = 0;
                    2:       dly = 1000;
                    default: dly = dfix;
                endcase
                if (q.size() == 0) chk("issue_without_cmd", 0, 1);
                else begin
                    chk("issue_a", alu_a, q[0].a);
                    chk("issue_b", alu_b, q[0].b);
                    chk("issue_op", alu_op, q[0].op);
                    chk("issue_is_alu_op", 32'(is_alu(q[0].op)), 1);
                end
                ml        = (alu_op == 3'd4) ? MIN_LAT_MUL : MIN_LAT_ALU;
                eff       = (dly > ml) ? dly : ml;
                cur_to    = (eff > TIMEOUT);
                exp_lat   = cur_to ? TIMEOUT + 1 : eff + 1;
                issue_cyc = cyc;
            end else if (alu_start) begin
                since++;
            end
            prev_start = alu_start;
            alu_done   = (dmode == 1) || (alu_start && since >= dly);
            alu_result = model('{a: alu_a, b: alu_b, op: alu_op});
            if (alu_op != 3'd4) alu_result[15:8] = 8'($urandom);

            if (rsp_valid) begin
                chk("start_low_in_resp", alu_start, 0);
                if (q.size() == 0) chk("rsp_without_cmd", 1, 0);
                else begin
                    c = q[0];
                    if (is_alu(c.op)) begin
                        ev = cur_to ? 16'h0 : model(c);
                        ee = cur_to;
                        if (!prev_rv) chk("issue_to_rsp_latency", cyc - issue_cyc, exp_lat);
                    end else begin
                        ev = 16'h0;
                        ee = (c.op != 3'd0);
                    end
                    chk("rsp_result", rsp_result, ev);
                    chk("rsp_op", rsp_op, c.op);
                    chk("rsp_err", rsp_err, ee);
                end
            end
            prev_rv = rsp_valid;
            chk("busy", busy, 32'(q.size() != 0));
        end
        case (ready_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'b0;
            default: rsp_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, output int pc);
        int g;
        g = 0;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
        while (!cmd_ready && g < 400) begin
            @(negedge clk);
            g++;
        end
        if (!cmd_ready) chk("cmd_accept_bound", 0, 1);
        else @(negedge clk);
        pc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int rc);
        int g;
        g = 0;
        while (!rsp_valid && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!rsp_valid) chk("rsp_wait_bound", 0, 1);
        rc = cyc;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (q.size() != 0 && g < 5000) begin
            @(negedge clk);
            g++;
        end
        chk("drain", q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pc, rc, s0, h0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_alu_start", alu_start, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_op", rsp_op, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_busy", busy, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // add 0x12+0x34, done high one cycle into start
        ready_mode = 0; dmode = 3; dfix = 1;
        send(8'h12, 8'h34, 3'd1, pc);
        @(negedge clk);
        chk("add_issue_latency", alu_start, 1);
        wait_rsp(rc);
        chk("add_latency", rc - pc, 3);
        chk("add_result", rsp_result, 16'h0046);
        chk("add_op", rsp_op, 1);
        chk("add_err", rsp_err, 0);
        wait_drain();

        // done stuck high across ops: add then 0xFF*0xFF
        dmode = 1;
        send(8'h01, 8'h02, 3'd1, pc);
        wait_drain();
        send(8'hFF, 8'hFF, 3'd4, pc);
        wait_rsp(rc);
        chk("mul_latency", rc - pc, 5);
        chk("mul_result", rsp_result, 16'hFE01);
        wait_drain();

        // timeout on xor
        dmode = 2;
        send(8'h5A, 8'h0F, 3'd3, pc);
        wait_rsp(rc);
        chk("timeout_latency", rc - pc, TIMEOUT + 2);
        chk("timeout_err", rsp_err, 1);
        chk("timeout_result", rsp_result, 0);
        wait_drain();

        // local ops never start the ALU
        dmode = 3; dfix = 1;
        s0 = n_starts;
        send(8'hAA, 8'h55, 3'd6, pc);
        wait_rsp(rc);
        chk("illegal_latency", rc - pc, 2);
        chk("illegal_err", rsp_err, 1);
        wait_drain();
        send(8'hAA, 8'h55, 3'd0, pc);
        wait_rsp(rc);
        chk("nop_latency", rc - pc, 2);
        chk("nop_err", rsp_err, 0);
        chk("nop_result", rsp_result, 0);
        wait_drain();
        chk("local_no_start", n_starts - s0, 0);

        // backpressure: one in flight plus a full FIFO
        ready_mode = 1; dmode = 3; dfix = 2;
        h0 = n_hs;
        for (int i = 0; i < 5; i++) send(8'(i + 1), 8'(3 * i), 3'(1 + (i % 4)), pc);
        repeat (3) @(negedge clk);
        chk("bp_full_ready", cmd_ready, 0);
        chk("bp_accepted", q.size(), 5);
        cmd_a = 8'h77; cmd_b = 8'h11; cmd_op = 3'd3; cmd_valid = 1'b1;
        repeat (5) @(negedge clk);
        chk("bp_blocked", q.size(), 5);
        ready_mode = 0;
        send(8'h77, 8'h11, 3'd3, pc);
        wait_drain();
        chk("bp_responses", n_hs - h0, 6);

        // reset while issuing with commands queued
        dmode = 2;
        for (int i = 0; i < 3; i++) send(8'h10, 8'h20, 3'd1, pc);
        repeat (2) @(negedge clk);
        chk("pre_reset_start", alu_start, 1);
        reset_n = 1'b0;
        q.delete();
        #1;
        chk("reset_start_drop", alu_start, 0);
        chk("reset_busy", busy, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        reset_n = 1'b1;
        h0 = n_hs;
        repeat (30) @(negedge clk);
        chk("post_reset_no_rsp", n_hs - h0, 0);
        chk("post_reset_idle", busy, 0);

        // randomised traffic
        dmode = 0; ready_mode = 2;
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), pc);
        end
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
